serial_add_ctrl: RTL and testbench

Bit-serial addition controller that time-shares a single 1-bit full-adder cell (the team's 3-input summer: sum = x^y^z, carry = majority) to add two WIDTH-bit operands, LSB first, one bit per clock. It sits between a requester issuing start/operands and the external combinational full-adder instance. It owns the operand shift registers, the carry flip-flop, the result register and the start/busy/done handshake.

---
 rtl/serial_add_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//
// Bit-serial adder controller. It adds two WIDTH-bit operands plus a carry-in,
// LSB first, one bit per clock. The adding itself is done by an external
// combinational 1-bit full-adder cell that this block time-shares.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              add request, sampled only while idle
//   a, b, cin          operands and carry-in, captured when start is accepted
//   fa_in1..fa_in3     to the full-adder cell: current bits of a and b, and the carry
//   fa_sum, fa_carry   from the full-adder cell (combinational)
//   busy, done         handshake; done is a one-cycle pulse marking a valid result
//   sum, cout, ovf     registered result, final carry-out and signed overflow.
//                      They hold their value until the next accepted start.

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_in1,
    output logic             fa_in2,
    output logic             fa_in3,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        fa_in1  = 1'b0;
        fa_in2  = 1'b0;
        fa_in3  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy    = 1'b1;
                fa_in1  = a_q[0];
                fa_in2  = b_q[0];
                fa_in3  = carry_q;
                // Result fills from the top, so after WIDTH shifts bit 0 sits at sum[0].
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_carry;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    cout_d  = fa_carry;
                    // carry_q is the carry into the MSB during this last step.
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl. It instantiates one 8-bit DUT and one 4-bit DUT,
// each wired to a behavioural full-adder cell.

module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // 8-bit instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       f1_8, f2_8, f3_8, fs8, fc8, busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    assign fs8 = f1_8 ^ f2_8 ^ f3_8;
    assign fc8 = (f1_8 & f2_8) | (f1_8 & f3_8) | (f2_8 & f3_8);

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .fa_in1(f1_8), .fa_in2(f2_8), .fa_in3(f3_8), .fa_sum(fs8), .fa_carry(fc8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // 4-bit instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       f1_4, f2_4, f3_4, fs4, fc4, busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    assign fs4 = f1_4 ^ f2_4 ^ f3_4;
    assign fc4 = (f1_4 & f2_4) | (f1_4 & f3_4) | (f2_4 & f3_4);

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .fa_in1(f1_4), .fa_in2(f2_4), .fa_in3(f3_4), .fa_sum(fs4), .fa_carry(fc4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on a w-bit add
    task automatic ref_add(input int w, input int a, input int b, input int c,
                           output int s, output int co, output int ov);
        int total, sa, sb, ssum;
        total = a + b + c;
        s     = total % (1 << w);
        co    = total >> w;
        sa    = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb    = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        ssum  = sa + sb + c;
        ov    = (ssum >= (1 << (w - 1)) || ssum < -(1 << (w - 1))) ? 1 : 0;
    endtask

    // One 8-bit add: probes the cell inputs, done timing, busy length, result and hold.
    // With poke set, start is pulsed with other operands during RUN and during DONE.
    task automatic do_add8(input string name, input int a, input int b, input int c,
                           input bit poke);
        int s, co, ov, done_at, done_cnt, busy_cnt, mask, cy;
        ref_add(8, a, b, c, s, co, ov);
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); cin8 = 1'(c);
        @(posedge clk); #1;  // accept edge
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        done_at = -1; done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) begin
                mask = (1 << i) - 1;
                cy   = (((a & mask) + (b & mask) + c) >> i) & 1;
                check({name, " fa_in"}, {f1_8, f2_8, f3_8},
                      {((a >> i) & 1) != 0, ((b >> i) & 1) != 0, cy != 0});
            end else begin
                check({name, " fa_in idle"}, {f1_8, f2_8, f3_8}, 0);
            end
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i == 8) begin
                check({name, " sum"}, sum8, s);
                check({name, " cout"}, cout8, co);
                check({name, " ovf"}, ovf8, ov);
            end
            if (poke && (i == 3 || i == 8)) begin
                start8 = 1'b1; a8 = 8'(~a); b8 = 8'(a); cin8 = 1'(~c);
            end
            if (poke && (i == 4 || i == 9)) start8 = 1'b0;
            @(posedge clk); #1;
        end
        check({name, " done cycle"}, done_at, 8);
        check({name, " done count"}, done_cnt, 1);
        check({name, " busy cycles"}, busy_cnt, 9);
        check({name, " sum held"}, {cout8, ovf8, sum8}, (co << 9) | (ov << 8) | s);
    endtask

    task automatic do_add4(input int a, input int b, input int c);
        int s, co, ov, done_at;
        ref_add(4, a, b, c, s, co, ov);
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c);
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'(~a); b4 = 4'(~b);
        done_at = -1;
        for (int i = 0; i <= 5; i++) begin
            if (done4 && done_at < 0) done_at = i;
            if (i == 4) check($sformatf("w4 %0h+%0h+%0d", a, b, c),
                              {cout4, ovf4, sum4}, (co << 5) | (ov << 4) | s);
            @(posedge clk); #1;
        end
        check($sformatf("w4 %0h+%0h+%0d done cycle", a, b, c), done_at, 4);
    endtask

    typedef struct {
        string name;
        int    a, b, c;
        int    s, co, ov;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int dcnt;
        vecs.push_back('{"3C+05",   'h3C, 'h05, 0, 'h41, 0, 0});
        vecs.push_back('{"FF+01",   'hFF, 'h01, 0, 'h00, 1, 0});
        vecs.push_back('{"7F+01",   'h7F, 'h01, 0, 'h80, 0, 1});
        vecs.push_back('{"A5+5A+1", 'hA5, 'h5A, 1, 'h00, 1, 0});
        vecs.push_back('{"80+80",   'h80, 'h80, 0, 'h00, 1, 1});
        vecs.push_back('{"40+40",   'h40, 'h40, 0, 'h80, 0, 1});
        vecs.push_back('{"00+00",   'h00, 'h00, 0, 'h00, 0, 0});

        // Reset state
        #1;
        check("reset outputs8", {busy8, done8, sum8, cout8, ovf8, f1_8, f2_8, f3_8}, 0);
        check("reset outputs4", {busy4, done4, sum4, cout4, ovf4, f1_4, f2_4, f3_4}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table: constant expectations cross-checked against the model
        foreach (vecs[i]) begin
            int s, co, ov;
            ref_add(8, vecs[i].a, vecs[i].b, vecs[i].c, s, co, ov);
            check({vecs[i].name, " table vs model"}, (co << 9) | (ov << 8) | s,
                  (vecs[i].co << 9) | (vecs[i].ov << 8) | vecs[i].s);
            do_add8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
            check({vecs[i].name, " dut result"}, {cout8, ovf8, sum8},
                  (vecs[i].co << 9) | (vecs[i].ov << 8) | vecs[i].s);
        end

        // start during RUN and DONE is ignored
        do_add8("ignore start", 'h3C, 'h05, 0, 1'b1);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done8 || busy8) dcnt++;
            @(posedge clk); #1;
        end
        check("no second op", dcnt, 0);
        check("ignore start result", sum8, 'h41);

        // Reset mid-RUN
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort outputs", {busy8, done8, sum8, cout8, ovf8, f1_8, f2_8, f3_8}, 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dcnt++;
        end
        check("abort no done", dcnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_add8("after reset", 'h3C, 'h05, 0, 1'b0);

        // Random operands against the model
        for (int i = 0; i < 30; i++)
            do_add8("rand", int'($urandom_range(255)), int'($urandom_range(255)),
                    int'($urandom_range(1)), 1'b0);

        // 4-bit corner case, then exhaustive sweep
        do_add4('hF, 'hF, 1);
        check("w4 F+F+1", {cout4, ovf4, sum4}, 6'b10_1111);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    do_add4(x, y, c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
